controlador_fifo: RTL and testbench
===================================

// Module: controlador_fifo
// PURPOSE
//  Control unit for the memory FIFO: sequences the shared dual-port memory from push/pop requests.
//  Generates write/read enables and addresses, tracks occupancy, and flags full/empty/almost states.
//  Handles overflow/underflow errors. Sits between the requester logic and the memory array.
//  Reuses the wrapping pointer-counter style of the contador block.
// PARAMETERS
//  ADDR_W   3   address width; memory depth DEPTH = 2**ADDR_W (8)
// PORTS
//  clk           in   1         clock; all state updates on rising edge
//  reset_L       in   1         asynchronous active-low reset
//  init          in   1         1 = (re)enter INIT and latch thresholds
//  umbral_alto   in   ADDR_W+1  almost_full threshold (occupancy >= umbral_alto)
//  umbral_bajo   in   ADDR_W+1  almost_empty threshold (occupancy <= umbral_bajo)
//  push          in   1         write request, data presented to memory same cycle
//  pop           in   1         read request
//  wr_en         out  1         memory write strobe
//  wr_addr       out  ADDR_W    memory write address
//  rd_en         out  1         memory read strobe
//  rd_addr       out  ADDR_W    memory read address
//  rd_valid      out  1         memory read data valid (1 cycle after accepted pop)
//  cuenta        out  ADDR_W+1  occupancy, 0..DEPTH
//  full          out  1         cuenta == DEPTH
//  empty         out  1         cuenta == 0
//  almost_full   out  1         cuenta >= latched umbral_alto
//  almost_empty  out  1         cuenta <= latched umbral_bajo
//  error         out  1         sticky: push while full or pop while empty
//  estado        out  3         current FSM state (debug)
// BEHAVIOUR
//  Reset (reset_L=0, async): estado=INIT; pointers=0; cuenta=0; wr_en=rd_en=rd_valid=0; error=0.
//   On reset: empty=1, full=0, almost_empty=1, almost_full=0; latched thresholds=0.
//  FSM (one-hot or binary encoding, 5 states):
//   INIT:   latch umbral_alto/umbral_bajo every cycle; ignore push/pop; init=0 -> IDLE.
//   IDLE:   cuenta==0; accepted push -> ACTIVE.
//   ACTIVE: cuenta in 1..DEPTH-1; transitions to FULL or IDLE by next cuenta value.
//   FULL:   cuenta==DEPTH; accepted pop -> ACTIVE.
//   ERROR:  entered on any overflow/underflow; push/pop ignored; exit only via init=1 -> INIT.
//   init=1 in any state -> INIT next cycle.
//   INIT also clears pointers, cuenta and error.
//  Acceptance (registered outputs, all update on the clk edge following the request):
//   push accepted iff state in {IDLE, ACTIVE} or (FULL and pop accepted same cycle).
//   pop accepted iff state in {ACTIVE, FULL} or (IDLE and push accepted same cycle: no, see below).
//   Pop on empty is never accepted, even with a simultaneous push (no fall-through).
//   push in FULL with no pop -> ERROR; pop in IDLE -> ERROR; error=1, held until INIT.
//  Accepted push: wr_en=1 and wr_addr=wr_ptr combinationally in the request cycle;
//   wr_ptr increments mod DEPTH at the edge.
//  Accepted pop: rd_en=1 and rd_addr=rd_ptr in the request cycle;
//   rd_ptr increments mod DEPTH at the edge; rd_valid=1 the following cycle.
//  cuenta: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
//   cuenta never exceeds DEPTH and never goes below 0.
//  Pointers wrap 7->0 naturally (ADDR_W-bit unsigned).
//  Flags are combinational decodes of registered cuenta and latched thresholds.
//  Reset asserted mid-operation: immediate return to reset values; in-flight rd_valid dropped.
// STRUCTURE
//  Shared package/include (fifo_defs.vh): ADDR_W default, DEPTH, state encodings.
//  One sub-module: contador_ptr (ADDR_W-bit wrapping counter with enable and sync clear),
//   instantiated twice (wr_ptr, rd_ptr).
//  cuenta, FSM and flags live in the top module.
// TESTING (probador + banco; compare conductual vs synthesized, same as other blocks)
//  1) Reset, then init=1 with alto=6, bajo=1, then init=0 -> INIT->IDLE; empty=1, almost_empty=1, cuenta=0.
//  2) 8 pushes -> wr_addr 0..7, cuenta=8, full=1; almost_full set when cuenta=6.
//  3) 8 pops from full -> rd_addr 0..7, rd_valid lags rd_en by 1 cycle, ends empty=1 in IDLE.
//  4) 5 pushes, 5 pops (wrapping writes 0..7 then 0..1) -> addresses wrap 7->0, cuenta correct.
//  5) Simultaneous push+pop at cuenta=3 and at FULL -> cuenta unchanged, both enables 1.
//     Push+pop at empty -> push only, cuenta=1.
//  6) Push at full -> error=1, ERROR state, further pushes ignored.
//     Then init pulse -> INIT, error=0, cuenta=0.
//     Reset_L low mid-stream -> all outputs at reset values within same cycle.

Source files
------------

// File: rtl/controlador_fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : controlador_fifo_pkg                                   |
// | Purpose : shared definitions for the FIFO controller: default    |
// |           address width and FSM state encoding.                  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package controlador_fifo_pkg;

  localparam int ADDR_W_DEF = 3;

  // Binary encoding, visible on the estado debug port.
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_FULL   = 3'd3,
    ST_ERROR  = 3'd4
  } estado_t;

endpackage : controlador_fifo_pkg
`default_nettype wire

// File: rtl/controlador_fifo_contador_ptr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : contador_ptr                                           |
// | Purpose : W-bit wrapping pointer counter with enable and         |
// |           synchronous clear (clear has priority over enable).    |
// | Ports   : clk, reset_L (async, active low), clear, en,           |
// |           count [W-1:0]                                          |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module contador_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  // Natural modulo-2**W wrap of an unsigned counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)   count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + W'(1);
  end

endmodule : contador_ptr
`default_nettype wire

// File: rtl/controlador_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : controlador_fifo                                       |
// | Purpose : control unit for a dual-port-memory FIFO. Turns push/  |
// |           pop requests into memory strobes and addresses, keeps  |
// |           occupancy, decodes full/empty/almost flags and traps   |
// |           overflow/underflow into a sticky ERROR state.          |
// | Ports   : clk, reset_L (async, active low), init,                |
// |           umbral_alto/umbral_bajo [ADDR_W:0] thresholds,         |
// |           push, pop -> wr_en/wr_addr, rd_en/rd_addr, rd_valid,   |
// |           cuenta [ADDR_W:0], full, empty, almost_full,           |
// |           almost_empty, error, estado [2:0]                      |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module controlador_fifo
  import controlador_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [ADDR_W:0]   umbral_alto,
  input  logic [ADDR_W:0]   umbral_bajo,
  input  logic              push,
  input  logic              pop,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [ADDR_W:0]   cuenta,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error,
  output logic [2:0]        estado
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  estado_t           state;
  logic [ADDR_W:0]   alto_q;
  logic [ADDR_W:0]   bajo_q;
  logic [ADDR_W:0]   cuenta_next;
  logic              pop_ok;
  logic              push_ok;
  logic              overflow;
  logic              underflow;
  logic              clr;

  // A pending init overrides any request in the same cycle.
  assign pop_ok    = !init && pop &&
                     (state == ST_ACTIVE || state == ST_FULL);
  // Push into a full FIFO only works when a pop frees a slot this cycle.
  assign push_ok   = !init && push &&
                     (state == ST_IDLE || state == ST_ACTIVE ||
                      (state == ST_FULL && pop_ok));
  // A pop on empty paired with a push is just a push (no fall-through),
  // so only a lone pop counts as underflow.
  assign overflow  = !init && (state == ST_FULL) && push && !pop;
  assign underflow = !init && (state == ST_IDLE) && pop && !push;

  // Clearing on the init cycle itself means INIT is entered already clean.
  assign clr       = init || (state == ST_INIT);

  assign wr_en     = push_ok;
  assign rd_en     = pop_ok;

  always_comb begin
    cuenta_next = cuenta;
    if (push_ok && !pop_ok)      cuenta_next = cuenta + (ADDR_W+1)'(1);
    else if (pop_ok && !push_ok) cuenta_next = cuenta - (ADDR_W+1)'(1);
  end

  contador_ptr #(.W(ADDR_W)) u_wr_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .clear   (clr),
    .en      (push_ok),
    .count   (wr_addr)
  );

  contador_ptr #(.W(ADDR_W)) u_rd_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .clear   (clr),
    .en      (pop_ok),
    .count   (rd_addr)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= ST_INIT;
      cuenta   <= '0;
      alto_q   <= '0;
      bajo_q   <= '0;
      rd_valid <= 1'b0;
      error    <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (state == ST_INIT) begin
        alto_q <= umbral_alto;
        bajo_q <= umbral_bajo;
      end
      if (clr) begin
        cuenta <= '0;
        error  <= 1'b0;
      end else begin
        cuenta <= cuenta_next;
        if (overflow || underflow) error <= 1'b1;
      end

      if (init) begin
        state <= ST_INIT;
      end else begin
        case (state)
          ST_INIT:  state <= ST_IDLE;
          ST_ERROR: state <= ST_ERROR;
          default: begin
            if (overflow || underflow)     state <= ST_ERROR;
            else if (cuenta_next == '0)    state <= ST_IDLE;
            else if (cuenta_next == DEPTH) state <= ST_FULL;
            else                           state <= ST_ACTIVE;
          end
        endcase
      end
    end
  end

  assign estado       = state;
  assign full         = (cuenta == DEPTH);
  assign empty        = (cuenta == '0);
  // A zero threshold (the reset value) would otherwise raise almost_full
  // on an empty FIFO, so an empty FIFO is never almost full.
  assign almost_full  = (cuenta != '0) && (cuenta >= alto_q);
  assign almost_empty = (cuenta <= bajo_q);

endmodule : controlador_fifo
`default_nettype wire

// File: tb/tb_controlador_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_controlador_fifo                                    |
// | Purpose : self-checking bench for controlador_fifo. Stimulus     |
// |           queues expected write/read addresses and rd_valid      |
// |           cycles; a monitor pops and compares whenever the DUT   |
// |           raises a strobe. Status is checked against hand values.|
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_controlador_fifo;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          init;
  logic [AW:0]   umbral_alto;
  logic [AW:0]   umbral_bajo;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [AW:0]   cuenta;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          error;
  logic [2:0]    estado;

  controlador_fifo #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .push         (push),
    .pop          (pop),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .cuenta       (cuenta),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error),
    .estado       (estado)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int exp_wr[$];
  int exp_rd[$];
  int exp_vld[$];
  int wp = 0;
  int rp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: compares only when the DUT presents a strobe.
  always @(negedge clk) begin
    if (reset_L) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) check("unexpected_wr_en", 1, 0);
        else check("wr_addr", int'(wr_addr), exp_wr.pop_front());
      end
      if (rd_en) begin
        if (exp_rd.size() == 0) check("unexpected_rd_en", 1, 0);
        else check("rd_addr", int'(rd_addr), exp_rd.pop_front());
      end
      if (rd_valid) begin
        if (exp_vld.size() == 0) check("unexpected_rd_valid", 1, 0);
        else check("rd_valid_cycle", cyc, exp_vld.pop_front());
      end
    end
  end

  // One request cycle; aw/ar are the hand-determined acceptance results.
  task automatic op(input bit p, input bit q, input bit aw, input bit ar);
    push = p;
    pop  = q;
    if (aw) begin exp_wr.push_back(wp); wp = (wp + 1) % 8; end
    if (ar) begin exp_rd.push_back(rp); rp = (rp + 1) % 8; exp_vld.push_back(cyc + 1); end
    @(posedge clk); #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic init_pulse();
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    wp = 0;
    rp = 0;
  endtask

  task automatic status(input string tag, input int c, input int st, input int e, input int f);
    check({tag, "_cuenta"}, int'(cuenta), c);
    check({tag, "_estado"}, int'(estado), st);
    check({tag, "_empty"},  int'(empty),  e);
    check({tag, "_full"},   int'(full),   f);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_L = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0;
    umbral_alto = 4'd6; umbral_bajo = 4'd1;
    #12;
    // Reset values.
    status("reset", 0, 0, 1, 0);
    check("reset_almost_empty", int'(almost_empty), 1);
    check("reset_almost_full", int'(almost_full), 0);
    check("reset_error", int'(error), 0);
    check("reset_rd_valid", int'(rd_valid), 0);
    @(posedge clk); #1;
    reset_L = 1'b1;

    // 1) init with alto=6 bajo=1, then INIT -> IDLE.
    init_pulse();
    check("init_estado", int'(estado), 0);
    @(posedge clk); #1;
    status("idle", 0, 1, 1, 0);
    check("idle_almost_empty", int'(almost_empty), 1);

    // 2) fill: addresses 0..7, almost_full from cuenta=6.
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 1, 0);
      check("fill_cuenta", int'(cuenta), i + 1);
      check("fill_almost_full", int'(almost_full), (i + 1 >= 6) ? 1 : 0);
      check("fill_almost_empty", int'(almost_empty), (i + 1 <= 1) ? 1 : 0);
    end
    status("full", 8, 3, 0, 1);

    // 3) drain: addresses 0..7, rd_valid one cycle after each rd_en.
    for (int i = 0; i < 8; i++) begin
      op(0, 1, 0, 1);
      check("drain_cuenta", int'(cuenta), 7 - i);
      check("drain_almost_empty", int'(almost_empty), (7 - i <= 1) ? 1 : 0);
    end
    @(posedge clk); #1;
    status("drained", 0, 1, 1, 0);

    // 4) two rounds of 5 push / 5 pop; second round wraps 7->0.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) op(1, 0, 1, 0);
      status("wrap_pushed", 5, 2, 0, 0);
      for (int i = 0; i < 5; i++) op(0, 1, 0, 1);
      @(posedge clk); #1;
      status("wrap_popped", 0, 1, 1, 0);
    end

    // 5) simultaneous push+pop at cuenta=3, at FULL, and at empty.
    for (int i = 0; i < 3; i++) op(1, 0, 1, 0);
    op(1, 1, 1, 1);
    status("pp_mid", 3, 2, 0, 0);
    for (int i = 0; i < 5; i++) op(1, 0, 1, 0);
    op(1, 1, 1, 1);
    status("pp_full", 8, 3, 0, 1);
    for (int i = 0; i < 8; i++) op(0, 1, 0, 1);
    @(posedge clk); #1;
    op(1, 1, 1, 0);
    status("pp_empty", 1, 2, 0, 0);
    check("pp_empty_error", int'(error), 0);
    op(0, 1, 0, 1);
    @(posedge clk); #1;

    // 6) overflow: push at full -> ERROR, later requests ignored.
    for (int i = 0; i < 8; i++) op(1, 0, 1, 0);
    op(1, 0, 0, 0);
    status("ovf", 8, 4, 0, 1);
    check("ovf_error", int'(error), 1);
    op(1, 0, 0, 0);
    op(0, 1, 0, 0);
    op(1, 1, 0, 0);
    check("ovf_hold_cuenta", int'(cuenta), 8);
    check("ovf_hold_error", int'(error), 1);
    init_pulse();
    status("recover", 0, 0, 1, 0);
    check("recover_error", int'(error), 0);
    @(posedge clk); #1;
    check("recover_idle", int'(estado), 1);

    // Underflow: lone pop on empty.
    op(0, 1, 0, 0);
    check("udf_estado", int'(estado), 4);
    check("udf_error", int'(error), 1);
    init_pulse();
    @(posedge clk); #1;

    // Reset mid-stream drops an in-flight rd_valid.
    op(1, 0, 1, 0);
    op(1, 0, 1, 0);
    op(0, 1, 0, 1);
    check("mid_rd_valid_pre", int'(rd_valid), 1);
    exp_vld.delete();
    reset_L = 1'b0;
    #1;
    status("midrst", 0, 0, 1, 0);
    check("midrst_rd_valid", int'(rd_valid), 0);
    check("midrst_error", int'(error), 0);
    check("midrst_almost_full", int'(almost_full), 0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    @(posedge clk); #1;

    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("vld_queue_drained", exp_vld.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule : tb_controlador_fifo
`default_nettype wire
